pkt_rr_mux: RTL and testbench
=============================

Name: pkt_rr_mux

Overview:
- Parametrised N-channel packet multiplexer: the synthesizable successor to the fixed single-path DUT our lab benches drive.
- Each input channel has its own FIFO.
- A packet-granular round-robin arbiter merges all channels onto one valid/ready output stream, tagged with the source channel.
- Sits between per-port packet sources and a single downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (2..16)
- DATA_W, 8, payload width in bits
- DEPTH, 8, per-channel FIFO depth in words (power of 2, >=2)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_CH  per-channel word valid
- in_last  in  NUM_CH  per-channel end-of-packet marker
- in_data  in  NUM_CH*DATA_W  flattened; channel c occupies bits [c*DATA_W +: DATA_W]
- in_ready  out  NUM_CH  per-channel FIFO not full
- out_valid  out  1  output word valid
- out_data  out  DATA_W  output payload
- out_last  out  1  end of output packet
- out_ch  out  $clog2(NUM_CH)  source channel of the current word
- out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release):
  - all FIFO pointers 0; arbiter IDLE; last_grant=NUM_CH-1, so ch0 has first priority.
  - out_valid=0, out_last=0, out_ch=0, out_data=0.
  - in_ready=1 on the first cycle after release.
- Input side:
  - a word is written when in_valid[c]&&in_ready[c], and {in_last,in_data} are stored together.
  - in_ready[c]=!full[c], driven combinationally from the registered count.
  - a write on a full FIFO cannot occur.
- FIFO:
  - read/write pointers are log2(DEPTH)+1 bits with a wrap bit; full = same index with differing wrap bit, empty = pointers equal.
  - first-word-fall-through head.
  - simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - when full, push is blocked that cycle; in_ready rises the cycle after a pop.
- Arbiter FSM states: IDLE, GRANT.
  - IDLE: if any FIFO is non-empty, pick the first non-empty channel scanning from (last_grant+1) mod NUM_CH upward with wrap; register grant and last_grant, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: out_valid = !empty[grant]; out_data/out_last = head of FIFO[grant]; out_ch = grant. Pop on out_valid&&out_ready.
  - A pop with last=1 returns to IDLE: one bubble cycle between packets.
  - Grant is held for the whole packet; no interleaving of packets on the output.
  - If the granted FIFO empties mid-packet, out_valid drops and grant is held until more words arrive.
- Latency: a word accepted at edge t into an idle system gives out_valid=1 after edge t+2.
- Output stability: while out_valid&&!out_ready, out_data, out_last and out_ch are held stable.
- Reset mid-packet: all FIFO contents and partial packets are discarded; no recovery.

Optional Feature:
- PKT_CNT_EN defined:
  - adds output port pkt_cnt, NUM_CH*16 bits, one counter per channel.
  - counter c increments on each output handshake with out_last=1 and out_ch=c.
  - counters saturate at 16'hFFFF and are cleared by reset.
- PKT_CNT_EN undefined: port and logic are absent.

Decomposition:
- Package pkt_rr_mux_pkg:
  - arb_state_e {IDLE, GRANT}
  - fifo_entry_t struct {last, data}
  - CNT_W=16 constant
- Sub-module chan_fifo: single-clock FWFT FIFO, instantiated NUM_CH times via generate.

Test Plan:
- Single packet: ch2 sends 3 words 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out_valid first high 2 cycles after the first accept; outputs 0x11,0x22,0x33 with out_ch=2 and out_last only on 0x33.
- Round robin: ch0..ch3 each load a 2-word packet simultaneously -> output packet order is ch0,ch1,ch2,ch3, with one idle cycle between packets; a second round again starts at ch0.
- Full/backpressure, DEPTH=8: ch1 pushes 10 words with out_ready=0 -> in_ready[1]=0 after the 8th accept; raise out_ready -> in_ready[1] returns high the cycle after the first pop; all 10 words arrive in order.
- Stall stability: hold out_ready=0 for 5 cycles mid-packet -> out_data/out_ch/out_last unchanged for those cycles; no word lost or duplicated.
- Mid-packet starvation: ch0 sends 0xA0 (no last), pauses 4 cycles, then 0xA1 with last, while ch1 holds a full packet -> out_valid low during the pause; ch1 is not granted until 0xA1 completes.
- Reset mid-operation: assert reset_n=0 while ch3 is half-delivered -> out_valid=0 immediately; after release all FIFOs are empty and the first new packet from ch0 wins arbitration; with PKT_CNT_EN, pkt_cnt reads 0.

Source files
------------

// File: rtl/pkt_rr_mux_pkg.sv
// Shared types and constants for the pkt_rr_mux packet multiplexer.
// Optional per-channel packet counters are enabled with the PKT_CNT_EN macro.
package pkt_rr_mux_pkg;

   localparam int CNT_W      = 16;
   localparam int MAX_DATA_W = 64;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Widest queued-word shape; each FIFO stores only DATA_W payload bits of it.
   typedef struct packed {
      logic                  last;
      logic [MAX_DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/pkt_rr_mux_chan_fifo.sv
// Single-clock first-word-fall-through FIFO: RAM array with a registered
// prefetch into a head register; occupancy counts the head word too.
module chan_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              last_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              full_o,
   input  logic              pop_i,
   output logic              head_valid_o,
   output logic              head_last_o,
   output logic [DATA_W-1:0] head_data_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t      mem_q [DEPTH];
   entry_t      head_q;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] fetch_ptr_q, fetch_ptr_d;
   logic        head_valid_q, head_valid_d;
   logic        push, pop, load;

   // rd_ptr tracks consumer pops, so the head word still occupies its slot.
   assign full_o = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign push   = push_i && !full_o;
   assign pop    = pop_i && head_valid_q;
   assign load   = (fetch_ptr_q != wr_ptr_q) && (!head_valid_q || pop);

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      fetch_ptr_d  = load ? fetch_ptr_q + PTR_ONE : fetch_ptr_q;
      head_valid_d = head_valid_q;
      if (load) begin
         head_valid_d = 1'b1;
      end else if (pop) begin
         head_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fetch_ptr_q  <= '0;
         head_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fetch_ptr_q  <= fetch_ptr_d;
         head_valid_q <= head_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= '{last: last_i, data: data_i};
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         head_q <= mem_q[fetch_ptr_q[AW-1:0]];
      end
   end

   assign head_valid_o = head_valid_q;
   assign head_last_o  = head_q.last;
   assign head_data_o  = head_q.data;

endmodule

// File: rtl/pkt_rr_mux.sv
// N-channel packet mux: per-channel FWFT FIFOs merged by a packet-granular
// round-robin arbiter. Define PKT_CNT_EN to add per-channel packet counters.
module pkt_rr_mux
   import pkt_rr_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_CH-1:0]         in_valid,
   input  logic [NUM_CH-1:0]         in_last,
   input  logic [NUM_CH*DATA_W-1:0]  in_data,
   output logic [NUM_CH-1:0]         in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   input  logic                      out_ready
`ifdef PKT_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]   pkt_cnt
`endif
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] head_valid;
   logic [NUM_CH-1:0] head_last;
   logic [NUM_CH-1:0] pop;
   logic [DATA_W-1:0] head_data [NUM_CH];

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d;
   logic [CH_W-1:0]   last_grant_q, last_grant_d;
   logic              pick_found;
   logic [CH_W-1:0]   pick_ch;
   logic [CH_W:0]     cand;
   logic              handshake;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_fifo (
            .clk          (clk),
            .rst_n        (reset_n),
            .push_i       (in_valid[gi]),
            .last_i       (in_last[gi]),
            .data_i       (in_data[gi*DATA_W +: DATA_W]),
            .full_o       (full[gi]),
            .pop_i        (pop[gi]),
            .head_valid_o (head_valid[gi]),
            .head_last_o  (head_last[gi]),
            .head_data_o  (head_data[gi])
         );
         assign in_ready[gi] = !full[gi];
         assign pop[gi]      = handshake && (grant_q == CH_W'(gi));
      end
   endgenerate

   // Scan from last_grant+1 with wrap; first non-empty channel wins.
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = {1'b0, last_grant_q} + (CH_W+1)'(i);
         if (cand >= (CH_W+1)'(NUM_CH)) begin
            cand = cand - (CH_W+1)'(NUM_CH);
         end
         if (!pick_found && head_valid[cand[CH_W-1:0]]) begin
            pick_found = 1'b1;
            pick_ch    = cand[CH_W-1:0];
         end
      end
   end

   assign out_valid = (state_q == GRANT) && head_valid[grant_q];
   assign out_data  = out_valid ? head_data[grant_q] : '0;
   assign out_last  = out_valid && head_last[grant_q];
   assign out_ch    = (state_q == GRANT) ? grant_q : '0;
   assign handshake = out_valid && out_ready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d      = GRANT;
               grant_d      = pick_ch;
               last_grant_d = pick_ch;
            end
         end
         GRANT: begin
            if (handshake && out_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= CH_W'(NUM_CH - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef PKT_CNT_EN
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else if (handshake && out_last && (out_ch == CH_W'(gi)) && (cnt_q != '1)) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_pkt_rr_mux.sv
// Directed self-checking bench for pkt_rr_mux (4 channels, 8-bit data, depth 8).
module tb_pkt_rr_mux;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_last;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_ready;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_last;
   logic [1:0]               out_ch;
   logic                     out_ready;
`ifdef PKT_CNT_EN
   logic [NUM_CH*16-1:0]     pkt_cnt;
`endif

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ch;
      logic       last;
      int         cyc;
   } hs_t;
   hs_t hs_q[$];

   pkt_rr_mux #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ch    (out_ch),
      .out_ready (out_ready)
`ifdef PKT_CNT_EN
      ,
      .pkt_cnt   (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshake log; cyc field is the rising edge at which the word is taken.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         hs_q.push_back('{data: out_data, ch: out_ch, last: out_last, cyc: cyc + 1});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = '0;
      in_last  = '0;
      in_data  = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      hs_q.delete();
   endtask

   task automatic wait_hs(input int n, input string name);
      int budget = 300;
      while (hs_q.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      vec++;
      if (hs_q.size() < n) begin
         miss++;
         $display("FAIL %s_timeout: got %0d handshakes want %0d", name, hs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      out_ready = 1'b0;
      clear_inputs();
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      vec++; if (out_valid !== 1'b0)  begin miss++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      vec++; if (out_last !== 1'b0)   begin miss++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      vec++; if (out_ch !== 2'd0)     begin miss++; $display("FAIL rst_out_ch: got %0d want 0", out_ch); end
      vec++; if (out_data !== 8'h00)  begin miss++; $display("FAIL rst_out_data: got %h want 00", out_data); end
      vec++; if (in_ready !== 4'hF)   begin miss++; $display("FAIL rst_in_ready: got %b want 1111", in_ready); end
`ifdef PKT_CNT_EN
      vec++; if (pkt_cnt !== '0)      begin miss++; $display("FAIL rst_pkt_cnt: got %h want 0", pkt_cnt); end
`endif
      hs_q.delete();
   endtask

   task automatic test_single();
      logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
      int acc;
      out_ready = 1'b1;
      hs_q.delete();
      clear_inputs();
      in_valid[2] = 1'b1; in_data[16 +: 8] = 8'h11;
      tick();
      acc = cyc;
      in_data[16 +: 8] = 8'h22;
      tick();
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL single_lat_t1: got out_valid %b want 0", out_valid); end
      in_data[16 +: 8] = 8'h33; in_last[2] = 1'b1;
      tick();
      clear_inputs();
      vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL single_lat_t2: got out_valid %b want 1", out_valid); end
      vec++; if (out_data !== 8'h11) begin miss++; $display("FAIL single_first_data: got %h want 11", out_data); end
      vec++; if (out_ch !== 2'd2)    begin miss++; $display("FAIL single_first_ch: got %0d want 2", out_ch); end
      wait_hs(3, "single");
      vec++; if (hs_q[0].cyc !== acc + 3) begin miss++; $display("FAIL single_hs_edge: got %0d want %0d", hs_q[0].cyc, acc + 3); end
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (hs_q[k].data !== exp_d[k] || hs_q[k].ch !== 2'd2 || hs_q[k].last !== (k == 2)) begin
            miss++;
            $display("FAIL single_word%0d: got data %h ch %0d last %b want data %h ch 2 last %b",
                     k, hs_q[k].data, hs_q[k].ch, hs_q[k].last, exp_d[k], (k == 2));
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         in_valid = 4'hF;
         in_last  = (w % 2 == 1) ? 4'hF : 4'h0;
         for (int c = 0; c < NUM_CH; c++) in_data[c*8 +: 8] = 8'((c << 4) + w + 1);
         tick();
      end
      clear_inputs();
      wait_hs(16, "rr");
      for (int k = 0; k < 16; k++) begin
         int         r = k / 8;
         int         c = (k % 8) / 2;
         int         j = k % 2;
         logic [7:0] ed = 8'((c << 4) + r * 2 + j + 1);
         vec++;
         if (hs_q[k].data !== ed || hs_q[k].ch !== 2'(c) || hs_q[k].last !== (j == 1)) begin
            miss++;
            $display("FAIL rr_word%0d: got data %h ch %0d last %b want data %h ch %0d last %b",
                     k, hs_q[k].data, hs_q[k].ch, hs_q[k].last, ed, c, (j == 1));
         end
         if (k > 0) begin
            int eg = (j == 0) ? 2 : 1;
            vec++;
            if (hs_q[k].cyc - hs_q[k-1].cyc !== eg) begin
               miss++;
               $display("FAIL rr_gap%0d: got %0d cycles want %0d", k, hs_q[k].cyc - hs_q[k-1].cyc, eg);
            end
         end
      end
`ifdef PKT_CNT_EN
      for (int c = 0; c < NUM_CH; c++) begin
         vec++;
         if (pkt_cnt[c*16 +: 16] !== 16'd2) begin
            miss++; $display("FAIL rr_pkt_cnt%0d: got %0d want 2", c, pkt_cnt[c*16 +: 16]);
         end
      end
`endif
      repeat (2) tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      hs_q.delete();
      clear_inputs();
      for (int i = 0; i < 8; i++) begin
         in_valid[1] = 1'b1; in_data[8 +: 8] = 8'(8'h40 + i);
         vec++; if (in_ready[1] !== 1'b1) begin miss++; $display("FAIL bp_ready%0d: got %b want 1", i, in_ready[1]); end
         tick();
      end
      vec++; if (in_ready[1] !== 1'b0) begin miss++; $display("FAIL bp_full: got %b want 0", in_ready[1]); end
      in_data[8 +: 8] = 8'h48;
      for (int s = 0; s < 3; s++) begin
         tick();
         vec++; if (in_ready[1] !== 1'b0) begin miss++; $display("FAIL bp_hold%0d: got %b want 0", s, in_ready[1]); end
      end
      out_ready = 1'b1;
      tick();
      vec++; if (in_ready[1] !== 1'b1) begin miss++; $display("FAIL bp_rise: got %b want 1", in_ready[1]); end
      tick();
      in_data[8 +: 8] = 8'h49; in_last[1] = 1'b1;
      vec++; if (in_ready[1] !== 1'b1) begin miss++; $display("FAIL bp_ready9: got %b want 1", in_ready[1]); end
      tick();
      clear_inputs();
      wait_hs(10, "bp");
      for (int k = 0; k < 10; k++) begin
         logic [7:0] ed = 8'(8'h40 + k);
         vec++;
         if (hs_q[k].data !== ed || hs_q[k].ch !== 2'd1 || hs_q[k].last !== (k == 9)) begin
            miss++;
            $display("FAIL bp_word%0d: got data %h ch %0d last %b want data %h ch 1 last %b",
                     k, hs_q[k].data, hs_q[k].ch, hs_q[k].last, ed, (k == 9));
         end
      end
      repeat (2) tick();
   endtask

   task automatic test_stall();
      int budget = 20;
      out_ready = 1'b0;
      hs_q.delete();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         in_valid[2] = 1'b1; in_data[16 +: 8] = 8'(8'h51 + i); in_last[2] = (i == 3);
         tick();
      end
      clear_inputs();
      while (!out_valid && budget > 0) begin
         tick();
         budget--;
      end
      vec++; if (out_data !== 8'h51) begin miss++; $display("FAIL stall_head: got %h want 51", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         vec++;
         if (out_valid !== 1'b1 || out_data !== 8'h52 || out_ch !== 2'd2 || out_last !== 1'b0) begin
            miss++;
            $display("FAIL stall_hold%0d: got valid %b data %h ch %0d last %b want valid 1 data 52 ch 2 last 0",
                     s, out_valid, out_data, out_ch, out_last);
         end
         tick();
      end
      out_ready = 1'b1;
      wait_hs(4, "stall");
      repeat (4) tick();
      vec++; if (hs_q.size() !== 4) begin miss++; $display("FAIL stall_count: got %0d words want 4", hs_q.size()); end
      for (int k = 0; k < 4; k++) begin
         logic [7:0] ed = 8'(8'h51 + k);
         vec++;
         if (hs_q[k].data !== ed || hs_q[k].ch !== 2'd2 || hs_q[k].last !== (k == 3)) begin
            miss++;
            $display("FAIL stall_word%0d: got data %h ch %0d last %b want data %h ch 2 last %b",
                     k, hs_q[k].data, hs_q[k].ch, hs_q[k].last, ed, (k == 3));
         end
      end
   endtask

   task automatic test_starve();
      logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hB1, 8'hB2};
      logic [1:0] exp_c [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      int budget = 20;
      out_ready = 1'b1;
      hs_q.delete();
      clear_inputs();
      in_valid = 4'b0011; in_data[0 +: 8] = 8'hA0; in_data[8 +: 8] = 8'hB1;
      tick();
      clear_inputs();
      in_valid[1] = 1'b1; in_data[8 +: 8] = 8'hB2; in_last[1] = 1'b1;
      tick();
      clear_inputs();
      while (hs_q.size() < 1 && budget > 0) begin
         tick();
         budget--;
      end
      vec++; if (hs_q.size() !== 1) begin miss++; $display("FAIL starve_first: got %0d words want 1", hs_q.size()); end
      for (int s = 0; s < 3; s++) begin
         vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL starve_gap%0d: got out_valid %b want 0", s, out_valid); end
         tick();
      end
      in_valid[0] = 1'b1; in_data[0 +: 8] = 8'hA1; in_last[0] = 1'b1;
      tick();
      clear_inputs();
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL starve_gap3: got out_valid %b want 0", out_valid); end
      vec++; if (hs_q.size() !== 1)  begin miss++; $display("FAIL starve_held: got %0d words want 1", hs_q.size()); end
      wait_hs(4, "starve");
      for (int k = 0; k < 4; k++) begin
         vec++;
         if (hs_q[k].data !== exp_d[k] || hs_q[k].ch !== exp_c[k] || hs_q[k].last !== (k % 2 == 1)) begin
            miss++;
            $display("FAIL starve_word%0d: got data %h ch %0d last %b want data %h ch %0d last %b",
                     k, hs_q[k].data, hs_q[k].ch, hs_q[k].last, exp_d[k], exp_c[k], (k % 2 == 1));
         end
      end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      int budget = 20;
      out_ready = 1'b1;
      hs_q.delete();
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         in_valid[3] = 1'b1; in_data[24 +: 8] = 8'(8'h71 + i); in_last[3] = (i == 3);
         tick();
      end
      clear_inputs();
      while (hs_q.size() < 2 && budget > 0) begin
         tick();
         budget--;
      end
      vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL rmid_pre: got out_valid %b want 1", out_valid); end
      #2;
      reset_n = 1'b0;
      #1;
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rmid_async: got out_valid %b want 0", out_valid); end
      vec++; if (out_ch !== 2'd0)    begin miss++; $display("FAIL rmid_ch: got %0d want 0", out_ch); end
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      hs_q.delete();
      vec++; if (in_ready !== 4'hF)  begin miss++; $display("FAIL rmid_ready: got %b want 1111", in_ready); end
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rmid_idle: got out_valid %b want 0", out_valid); end
`ifdef PKT_CNT_EN
      vec++; if (pkt_cnt !== '0)     begin miss++; $display("FAIL rmid_pkt_cnt: got %h want 0", pkt_cnt); end
`endif
      in_valid = 4'b1001; in_last = 4'b1001;
      in_data[0 +: 8] = 8'hC1; in_data[24 +: 8] = 8'hD1;
      tick();
      clear_inputs();
      wait_hs(2, "rmid");
      repeat (6) tick();
      vec++; if (hs_q.size() !== 2) begin miss++; $display("FAIL rmid_count: got %0d words want 2", hs_q.size()); end
      vec++;
      if (hs_q[0].data !== 8'hC1 || hs_q[0].ch !== 2'd0 || hs_q[0].last !== 1'b1) begin
         miss++; $display("FAIL rmid_first: got data %h ch %0d last %b want data c1 ch 0 last 1",
                          hs_q[0].data, hs_q[0].ch, hs_q[0].last);
      end
      vec++;
      if (hs_q[1].data !== 8'hD1 || hs_q[1].ch !== 2'd3 || hs_q[1].last !== 1'b1) begin
         miss++; $display("FAIL rmid_second: got data %h ch %0d last %b want data d1 ch 3 last 1",
                          hs_q[1].data, hs_q[1].ch, hs_q[1].last);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      out_ready = 1'b0;
      clear_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_stall();
      test_starve();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
